// File: rtl/reg_8bit_bus_pkg.sv
// Shared constants for bus-attached datapath registers.
package reg_8bit_bus_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] busWord_t;

endpackage

// File: rtl/reg_8bit_bus_if.sv
// Control and observation signals of a bus-attached datapath register.
interface reg_8bit_bus_if
  import reg_8bit_bus_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] mem_out;

  modport master (
    output wr_en,
    output rd_en,
    input  mem_out
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    output mem_out
  );

endinterface

// File: rtl/reg_8bit_bus_tristate_buf.sv
// Output-enable buffer: drives data_i onto data_o when oe_i is high, otherwise releases it.
module reg_8bit_bus_tristate_buf
  import reg_8bit_bus_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             oe_i,
  output wire  [WIDTH-1:0] data_o
);

  assign data_o = oe_i ? data_i : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_8bit_bus.sv
// General-purpose datapath register on the shared tri-state system bus.
// It loads from the bus on wr_en and drives the bus on rd_en; mem_out always shows the contents.
module reg_8bit_bus
  import reg_8bit_bus_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  reg_8bit_bus_if.slave    ctl
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Loading from the bus while driving it makes the register reload its own value.
  always_comb begin
    data_d = data_q;
    if (ctl.wr_en) begin
      data_d = bus;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ctl.mem_out = data_q;

  reg_8bit_bus_tristate_buf #(
    .WIDTH (WIDTH)
  ) u_busDriver (
    .data_i (data_q),
    .oe_i   (ctl.rd_en),
    .data_o (bus)
  );

endmodule

// File: tb/tb_reg_8bit_bus.sv
// Directed scoreboard bench for reg_8bit_bus: bench drives the bus through its own tri-state driver.
module tb_reg_8bit_bus;
  import reg_8bit_bus_pkg::*;

  typedef struct {
    string    tag;
    busWord_t expMem;
    busWord_t expBus;
  } expect_t;

  logic     clk = 1'b0;
  logic     clr;
  logic     benchOe;
  busWord_t benchData;
  wire  [DATA_W-1:0] bus;

  int vectors     = 0;
  int miscompares = 0;
  expect_t scoreboard[$];

  reg_8bit_bus_if #(.WIDTH(DATA_W)) busIf ();

  assign bus = benchOe ? benchData : {DATA_W{1'bz}};

  reg_8bit_bus #(
    .WIDTH (DATA_W)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus),
    .ctl (busIf.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the negedge and record what the next negedge must show.
  task automatic applyStimulus(input string tag, input logic c, input logic wr, input logic rd,
                               input logic oe, input busWord_t data,
                               input busWord_t expMem, input busWord_t expBus);
    expect_t e;
    clr          = c;
    busIf.wr_en  = wr;
    busIf.rd_en  = rd;
    benchOe      = oe;
    benchData    = data;
    e.tag        = tag;
    e.expMem     = expMem;
    e.expBus     = expBus;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    expect_t e;
    @(negedge clk);
    vectors++;
    assert (scoreboard.size() != 0) else begin
      miscompares++;
      $error("FAIL scoreboard: got empty queue, want pending entry");
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      vectors++;
      assert (busIf.mem_out === e.expMem) else begin
        miscompares++;
        $error("FAIL %s mem_out: got %h want %h", e.tag, busIf.mem_out, e.expMem);
      end
      vectors++;
      assert (bus === e.expBus) else begin
        miscompares++;
        $error("FAIL %s bus: got %h want %h", e.tag, bus, e.expBus);
      end
    end
  endtask

  initial begin
    clr         = 1'b0;
    busIf.wr_en = 1'b0;
    busIf.rd_en = 1'b0;
    benchOe     = 1'b0;
    benchData   = '0;
    @(negedge clk);

    applyStimulus("clrOverWr",  1, 1, 0, 1, 8'h8F, 8'h00, 8'h8F); checkOutput();
    applyStimulus("clrRead",    1, 0, 1, 0, 8'h00, 8'h00, 8'h00); checkOutput();
    applyStimulus("loadCF",     0, 1, 0, 1, 8'hCF, 8'hCF, 8'hCF); checkOutput();
    applyStimulus("readCF",     0, 0, 1, 0, 8'h00, 8'hCF, 8'hCF); checkOutput();
    applyStimulus("releaseBus", 0, 0, 0, 1, 8'h35, 8'hCF, 8'h35); checkOutput();
    applyStimulus("hold9B",     0, 0, 0, 1, 8'h9B, 8'hCF, 8'h9B); checkOutput();
    applyStimulus("clrPrioFF",  1, 1, 0, 1, 8'hFF, 8'h00, 8'hFF); checkOutput();
    applyStimulus("load8C",     0, 1, 0, 1, 8'h8C, 8'h8C, 8'h8C); checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("loopback", 0, 1, 1, 0, 8'h00, 8'h8C, 8'h8C); checkOutput();
    end
    applyStimulus("clrWhileRd", 1, 0, 1, 0, 8'h00, 8'h00, 8'h00); checkOutput();
    applyStimulus("load5A",     0, 1, 0, 1, 8'h5A, 8'h5A, 8'h5A); checkOutput();
    applyStimulus("read5A",     0, 0, 1, 0, 8'h00, 8'h5A, 8'h5A); checkOutput();
    applyStimulus("clrLoopRd",  1, 1, 1, 0, 8'h00, 8'h00, 8'h00); checkOutput();
    applyStimulus("loadA5",     0, 1, 0, 1, 8'hA5, 8'hA5, 8'hA5); checkOutput();
    applyStimulus("holdRd",     0, 0, 1, 0, 8'h00, 8'hA5, 8'hA5); checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_8bit_bus.md
Name: reg_8bit_bus

Overview:
- 8-bit general-purpose register (e.g. A/B register) for the 8-bit CPU datapath.
- Attaches to the shared bidirectional system bus.
- wr_en loads the register from the bus on the clock edge. rd_en drives the stored value onto the bus; otherwise the block's bus driver is high-Z.
- The stored value is also always available on a dedicated non-tristated output for the ALU and display.

Parameters:
- WIDTH, 8, register and bus width in bits. Only 8 is required; all behaviour below scales with WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- clr  input  1  reset/clear: synchronous, active-high. This is the single clock domain's reset.
- wr_en  input  1  load enable: capture bus into register at rising clk.
- rd_en  input  1  output enable: drive register value onto bus.
- bus  inout  WIDTH  shared tri-state system bus.
- mem_out  output  WIDTH  current register contents, always driven.

Behaviour:
- State: one WIDTH-bit register q. The power-up value is undefined until the first clr edge; q becomes 0 at the first rising clk with clr=1.
- Update at rising clk, priority order:
  - clr=1 -> q <= 0. This overrides wr_en regardless of bus contents.
  - else wr_en=1 -> q <= bus (value sampled at the edge).
  - else q holds.
- Latency: a new value appears on mem_out (and on bus if rd_en) one edge after wr_en/clr is sampled. There is no combinational bus->mem_out path.
- mem_out = q at all times, independent of rd_en, wr_en and clr.
- Bus driver is purely combinational:
  - rd_en=1 -> bus = q.
  - rd_en=0 -> bus = all bits Z.
  - rd_en has no effect on q.
- clr with rd_en=1: after the clearing edge the bus carries 0. clr does not force the driver off.
- wr_en=1 with rd_en=1 (self-loopback): the bus carries q, so q reloads itself and holds. External drivers must be released in this case; the block does not arbitrate bus contention.
- Reset mid-operation: a clr edge during any load/read sequence yields q=0 on that edge. A pending wr_en is discarded.
- No X-propagation fixups: a Z/X bus sampled with wr_en=1 is stored as-is.

Decomposition:
- Shared package: WIDTH default constant (DATA_W=8) used by all bus-attached datapath registers.
- Natural split: one sub-module tristate_buf (WIDTH-bit output-enable buffer: in, oe, out).
- Remainder is the enabled-load flop with synchronous clear.

Test Plan:
- Bench setup: bench drives bus through its own tri-state driver (bench_oe). Inputs change on negedge; checks are made at the following negedge.
- clr=1, wr_en=1, rd_en=0, bench drives 8'h8F -> after edge mem_out=8'h00, DUT bus driver Z (bus=8'h8F from bench).
- clr=1, wr_en=0, rd_en=1, bench released -> mem_out=8'h00, bus=8'h00.
- clr=0, wr_en=1, rd_en=0, bench drives 8'hCF -> mem_out=8'hCF next edge. Bus shows only the bench value (DUT driver Z).
- clr=0, wr_en=0, rd_en=1, bench released -> bus=8'hCF, mem_out=8'hCF. Then rd_en=0 -> bus=8'hZZ, mem_out still 8'hCF.
- Hold/priority: q=8'hCF; clr=0, wr_en=0, bench drives 8'h9B -> mem_out stays 8'hCF. Next cycle clr=1, wr_en=1, bench drives 8'hFF -> mem_out=8'h00.
- Loopback: q=8'h8C; wr_en=1, rd_en=1, bench released for 3 cycles -> bus=8'h8C and mem_out=8'h8C every cycle.
